// File: rtl/gcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one GCD core between N_REQ requesters.
// Define GCD_ARB_TIMEOUT_EN to build the WAIT-state timeout (forced error response).
module gcd_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] REQ_A,
  input  logic [N_REQ*W-1:0] REQ_B,
  output logic [N_REQ-1:0]   ACK,
  output logic [W-1:0]       RES_Y,
  output logic               RES_ERR,
  output logic               RES_TO,
  output logic               BUSY,
  output logic               GCD_START,
  output logic [W-1:0]       GCD_A,
  output logic [W-1:0]       GCD_B,
  input  logic [W-1:0]       GCD_Y,
  input  logic               GCD_DONE,
  input  logic               GCD_ERROR
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, grant_c;
  logic             grant_vld_c;
  logic [W-1:0]     a_q, a_d, b_q, b_d, y_q, y_d, res_y_q, res_y_d;
  logic             err_q, err_d, res_err_q, res_err_d;
  logic             busy_q, busy_d, start_q, start_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [W-1:0]     req_a_arr [N_REQ];
  logic [W-1:0]     req_b_arr [N_REQ];

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d, res_to_q, res_to_d;
  logic             timeout_c;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_a_arr[g] = REQ_A[g*W +: W];
    assign req_b_arr[g] = REQ_B[g*W +: W];
  end

  // First pending request at or after ptr, wrapping modulo N_REQ
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_vld_c && REQ[IDX_W'((32'(ptr_q) + k) % N_REQ)]) begin
        grant_vld_c = 1'b1;
        grant_c     = IDX_W'((32'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld_c) begin
          state_d = S_ISSUE;
          idx_d   = grant_c;
          a_d     = req_a_arr[grant_c];
          b_d     = req_b_arr[grant_c];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // DONE wins over a timeout expiring on the same edge
        if (GCD_DONE) begin
          state_d = S_RESP;
          y_d     = GCD_Y;
          err_d   = GCD_ERROR;
`ifdef GCD_ARB_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          state_d = S_RESP;
          y_d     = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = IDX_W'((32'(idx_q) + 32'd1) % N_REQ);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    start_d   = (state_d == S_ISSUE);
    ack_d     = (state_d == S_RESP) ? (N_REQ'(1) << idx_d) : '0;
    res_y_d   = (state_d == S_RESP) ? y_d : '0;
    res_err_d = (state_d == S_RESP) ? err_d : 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
    res_to_d  = (state_d == S_RESP) ? to_d : 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= '0;
      res_y_q   <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      y_q       <= y_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      res_y_q   <= res_y_d;
      res_err_q <= res_err_d;
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      to_q     <= 1'b0;
      res_to_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      res_to_q <= res_to_d;
    end
  end

  assign RES_TO = res_to_q;
`else
  assign RES_TO = 1'b0;
`endif

  assign ACK       = ack_q;
  assign RES_Y     = res_y_q;
  assign RES_ERR   = res_err_q;
  assign BUSY      = busy_q;
  assign GCD_START = start_q;
  assign GCD_A     = a_q;
  assign GCD_B     = b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: event-time transaction model plus a stub GCD core.
// Build with GCD_ARB_TIMEOUT_EN to also exercise the WAIT timeout (TIMEOUT_CYC=10).
module tb_gcd_arbiter;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned TO = 10;
`else
  localparam int unsigned TO = 255;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] REQ_A = '0, REQ_B = '0;
  logic [3:0]  ACK;
  logic [7:0]  RES_Y, GCD_A, GCD_B;
  logic        RES_ERR, RES_TO, BUSY, GCD_START;
  logic [7:0]  GCD_Y = '0;
  logic        GCD_DONE = 1'b0, GCD_ERROR = 1'b0;

  gcd_arbiter #(.N_REQ(4), .W(8), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .ACK(ACK), .RES_Y(RES_Y), .RES_ERR(RES_ERR), .RES_TO(RES_TO), .BUSY(BUSY),
    .GCD_START(GCD_START), .GCD_A(GCD_A), .GCD_B(GCD_B),
    .GCD_Y(GCD_Y), .GCD_DONE(GCD_DONE), .GCD_ERROR(GCD_ERROR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    int x = int'(a), y = int'(b), t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Stub core contract: 0/0 is an error and reports 8'hEE, otherwise Euclid's gcd
  function automatic logic [7:0] core_y(input logic [7:0] a, input logic [7:0] b);
    return (a == 0 && b == 0) ? 8'hEE : gcd_f(a, b);
  endfunction

  // Requester-side operand record (what each requester offered when it raised REQ)
  logic [7:0] op_a [4];
  logic [7:0] op_b [4];

  // Model state
  logic       rst_s = 1'b1;
  logic [3:0] req_s = '0;
  int  cyc = 0, free_at = 0, m_ptr = 0, g = 0;
  int  start_cyc = 0, ack_cyc = 0, n_start = 0;
  bit  active = 0, ack_sched = 0;
  logic [7:0] exp_y = '0;
  bit  exp_err = 0, exp_to = 0;
  // Stub core state and knobs
  int  core_lat = 2, core_cnt = 0;
  logic [7:0] core_a = '0, core_b = '0;
  bit  spur_idle = 0, spur_on_start = 0;

  always @(posedge CLK) begin
    rst_s = RST;
    req_s = REQ;
  end

  // Per-cycle compare, then stub-core update
  always @(negedge CLK) begin
    logic [3:0] e_ack;
    bit e_start, found;
    cyc++;
    if (rst_s) begin
      chk("rst_ack", ACK, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_start", GCD_START, 0);
      chk("rst_res_y", RES_Y, 0);
      chk("rst_res_err", RES_ERR, 0);
      chk("rst_res_to", RES_TO, 0);
      chk("rst_gcd_a", GCD_A, 0);
      chk("rst_gcd_b", GCD_B, 0);
      active = 0; ack_sched = 0; m_ptr = 0; free_at = cyc; core_cnt = 0;
      GCD_DONE = 0; GCD_Y = '0; GCD_ERROR = 0;
    end else begin
      e_start = !active && (cyc - 1 >= free_at) && (req_s != 0);
      chk("start", GCD_START, e_start);
      if (e_start) begin
        found = 0;
        for (int k = 0; k < 4; k++)
          if (!found && req_s[(m_ptr + k) % 4]) begin
            found = 1;
            g = (m_ptr + k) % 4;
          end
        chk("gcd_a", GCD_A, op_a[g]);
        chk("gcd_b", GCD_B, op_b[g]);
        n_start++; active = 1; start_cyc = cyc; ack_sched = 0;
      end
      chk("busy", BUSY, active);
      e_ack = (active && ack_sched && cyc == ack_cyc) ? 4'(1 << g) : 4'd0;
      chk("ack", ACK, e_ack);
      chk("res_y", RES_Y, (e_ack != 0) ? exp_y : 8'd0);
      chk("res_err", RES_ERR, (e_ack != 0) ? exp_err : 1'b0);
      chk("res_to", RES_TO, (e_ack != 0) ? exp_to : 1'b0);
      if (e_ack != 0) begin
        active = 0; free_at = cyc + 1; m_ptr = (g + 1) % 4;
      end

      GCD_DONE = 0; GCD_Y = '0; GCD_ERROR = 0;
      if (GCD_START) begin
        core_a = GCD_A; core_b = GCD_B; core_cnt = core_lat;
        if (spur_on_start) begin
          GCD_DONE = 1; GCD_Y = 8'h55; GCD_ERROR = 1;
        end
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          GCD_DONE = 1; GCD_Y = core_y(core_a, core_b); GCD_ERROR = (core_a == 0 && core_b == 0);
        end
      end
      if (spur_idle && !active) begin
        spur_idle = 0; GCD_DONE = 1; GCD_Y = 8'h55; GCD_ERROR = 1;
      end

      // A response is owed one cycle after DONE is seen in WAIT (or after timeout)
      if (active && !ack_sched && cyc > start_cyc) begin
        if (GCD_DONE) begin
          ack_sched = 1; ack_cyc = cyc + 1;
          exp_y = core_y(op_a[g], op_b[g]); exp_err = (op_a[g] == 0 && op_b[g] == 0); exp_to = 0;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (cyc == start_cyc + int'(TO)) begin
          ack_sched = 1; ack_cyc = cyc + 1; exp_y = '0; exp_err = 1; exp_to = 1;
        end
`endif
      end
    end
  end

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i] = a; op_b[i] = b;
    REQ_A[i*8 +: 8] = a;
    REQ_B[i*8 +: 8] = b;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      n++;
      if (GCD_START) break;
    end
  endtask

  task automatic wait_ack(input string name, input logic [3:0] e_ack, input logic [7:0] e_y,
                          input logic e_err, input logic e_to, input bit drop, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      n++;
      if (ACK != 0) break;
    end
    chk({name, "_ack"}, ACK, e_ack);
    chk({name, "_y"}, RES_Y, e_y);
    chk({name, "_err"}, RES_ERR, e_err);
    chk({name, "_to"}, RES_TO, e_to);
    if (drop) REQ = REQ & ~ACK;
  endtask

  initial begin
    int n1, n2, s0;
    for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
    repeat (3) @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);

    // Requester 0: 21,6 -> 3; latency 2 + core latency from REQ raise
    core_lat = 3;
    set_op(0, 8'd21, 8'd6);
    REQ[0] = 1;
    wait_start(n1);
    chk("t1_gcd_a", GCD_A, 21);
    chk("t1_gcd_b", GCD_B, 6);
    wait_ack("t1", 4'b0001, 8'd3, 0, 0, 1, n2);
    chk("t1_latency", n1 + n2, 5);

    // Requester 2 with operand change and early REQ drop, then requester 1
    core_lat = 1;
    set_op(2, 8'd75, 8'd60);
    REQ[2] = 1;
    wait_start(n1);
    REQ_A[23:16] = 8'd99;
    REQ[2] = 0;
    wait_ack("t2a", 4'b0100, 8'd15, 0, 0, 1, n2);
    spur_idle = 1;
    repeat (3) @(negedge CLK);
    set_op(1, 8'd5, 8'd145);
    REQ[1] = 1;
    wait_ack("t2b", 4'b0010, 8'd5, 0, 0, 1, n2);

    // Requester 3: 0,0 -> core error passes through, spurious DONE during ISSUE
    core_lat = 2;
    spur_on_start = 1;
    set_op(3, 8'd0, 8'd0);
    REQ[3] = 1;
    wait_ack("t3", 4'b1000, 8'hEE, 1, 0, 1, n2);
    spur_on_start = 0;

    // Fairness from reset, each requester drops on ACK
    RST = 1;
    @(negedge CLK);
    RST = 0;
    set_op(0, 8'd12, 8'd18);
    set_op(1, 8'd35, 8'd14);
    set_op(2, 8'd81, 8'd27);
    set_op(3, 8'd17, 8'd5);
    s0 = n_start;
    REQ = 4'b1111;
    wait_ack("t4_0", 4'b0001, 8'd6, 0, 0, 1, n2);
    wait_ack("t4_1", 4'b0010, 8'd7, 0, 0, 1, n2);
    wait_ack("t4_2", 4'b0100, 8'd27, 0, 0, 1, n2);
    wait_ack("t4_3", 4'b1000, 8'd1, 0, 0, 1, n2);
    repeat (3) @(negedge CLK);
    chk("t4_starts", n_start - s0, 4);

    // All four held high continuously: order wraps back to 0
    REQ = 4'b1111;
    wait_ack("t4h_0", 4'b0001, 8'd6, 0, 0, 0, n2);
    wait_ack("t4h_1", 4'b0010, 8'd7, 0, 0, 0, n2);
    wait_ack("t4h_2", 4'b0100, 8'd27, 0, 0, 0, n2);
    wait_ack("t4h_3", 4'b1000, 8'd1, 0, 0, 0, n2);
    wait_ack("t4h_4", 4'b0001, 8'd6, 0, 0, 0, n2);
    REQ = 4'b0000;
    repeat (3) @(negedge CLK);

    // Reset during WAIT aborts silently; the still-pending request then completes
    core_lat = 20;
    set_op(1, 8'd9, 8'd6);
    REQ[1] = 1;
    wait_start(n1);
    repeat (3) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk("t5_busy", BUSY, 0);
    chk("t5_start", GCD_START, 0);
    chk("t5_ack", ACK, 0);
    core_lat = 2;
    RST = 0;
    wait_ack("t5", 4'b0010, 8'd3, 0, 0, 1, n2);

`ifdef GCD_ARB_TIMEOUT_EN
    // Core never answers: forced error response 10 cycles after entering WAIT
    repeat (2) @(negedge CLK);
    core_lat = 0;
    set_op(2, 8'd8, 8'd12);
    REQ[2] = 1;
    wait_start(n1);
    wait_ack("t6", 4'b0100, 8'd0, 1, 1, 1, n2);
    chk("t6_wait_cycles", n2, 11);
    core_lat = 2;
`endif

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t limit 500000", $time);
    $fatal(1);
  end

endmodule
